branch_resolver: RTL and testbench

//  Consumer end of the branch-compare interface: decodes Funct3, drives BrUn back
//   to the comparator, turns BrEq/BrLT into a taken decision.

---
 rtl/branch_resolver.sv | 107 ++++++++++
 tb/tb_branch_resolver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolution stage: funct3 decode, taken decision, 2-bit BHT prediction
// and update, registered mispredict/error flags and saturating perf counters.
module branch_resolver #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BrValid,
  input  logic [2:0]       Funct3,
  input  logic [31:0]      BrPC,
  input  logic             BrPredTaken,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  output logic             Taken,
  input  logic [31:0]      LookupPC,
  output logic             PredTaken,
  output logic             Mispredict,
  output logic             BrErr,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       bht_q [ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;
  logic [1:0]       upd_old;
  logic [1:0]       upd_d;
  logic             legal;
  logic             taken_c;
  logic             mis_c;
  logic             mis_q;
  logic             err_q;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             unused_pc_bits;

  assign upd_idx  = BrPC[IDX_W+1:2];
  assign look_idx = LookupPC[IDX_W+1:2];
  assign unused_pc_bits = ^{BrPC[31:IDX_W+2], BrPC[1:0],
                            LookupPC[31:IDX_W+2], LookupPC[1:0]};

  // funct3 010/011 are not branch encodings
  assign BrUn  = Funct3[1];
  assign legal = BrValid & (Funct3[2:1] != 2'b01);

  always_comb begin
    taken_c = 1'b0;
    if (legal) begin
      case (Funct3)
        3'b000:  taken_c = BrEq;
        3'b001:  taken_c = ~BrEq;
        3'b100:  taken_c = BrLT;
        3'b101:  taken_c = ~BrLT;
        3'b110:  taken_c = BrLT;
        3'b111:  taken_c = ~BrLT;
        default: taken_c = 1'b0;
      endcase
    end
  end

  assign Taken     = taken_c;
  assign PredTaken = bht_q[look_idx][1];
  assign mis_c     = legal & (taken_c != BrPredTaken);

  always_comb begin
    upd_old = bht_q[upd_idx];
    upd_d   = upd_old;
    if (taken_c) begin
      if (upd_old != 2'b11) upd_d = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_d = upd_old - 2'b01;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (legal && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
    if (mis_c && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (legal) bht_q[upd_idx] <= upd_d;
      mis_q  <= mis_c;
      err_q  <= BrValid & ~legal;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign Mispredict      = mis_q;
  assign BrErr           = err_q;
  assign BranchCount     = bcnt_q;
  assign MispredictCount = mcnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vectors, a behavioural reference model
// checked every cycle, and literal expectations at the key scenario points.
module tb_branch_resolver;

  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             BrValid;
  logic [2:0]       Funct3;
  logic [31:0]      BrPC;
  logic             BrPredTaken;
  logic             BrEq;
  logic             BrLT;
  logic             BrUn;
  logic             Taken;
  logic [31:0]      LookupPC;
  logic             PredTaken;
  logic             Mispredict;
  logic             BrErr;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredictCount;

  branch_resolver #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .BrValid(BrValid), .Funct3(Funct3), .BrPC(BrPC),
    .BrPredTaken(BrPredTaken), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .Taken(Taken), .LookupPC(LookupPC), .PredTaken(PredTaken),
    .Mispredict(Mispredict), .BrErr(BrErr), .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_bht[16];
  int m_bc, m_mc;
  bit m_mis, m_err;
  bit model_valid = 0;

  function automatic bit is_legal(input bit v, input bit [2:0] f3);
    return v && (f3 != 3'd2) && (f3 != 3'd3);
  endfunction

  function automatic bit ref_taken(input bit v, input bit [2:0] f3, input bit eq, input bit lt);
    if (!is_legal(v, f3)) return 1'b0;
    case (f3)
      3'd0: return eq;        // BEQ
      3'd1: return !eq;       // BNE
      3'd4, 3'd6: return lt;  // BLT / BLTU
      default: return !lt;    // BGE / BGEU
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_bc = 0; m_mc = 0; m_mis = 0; m_err = 0;
      model_valid = 1;
    end else if (model_valid) begin
      bit lg, tk, mp;
      int k;
      lg = is_legal(BrValid, Funct3);
      tk = ref_taken(BrValid, Funct3, BrEq, BrLT);
      mp = lg && (tk != BrPredTaken);
      if (lg) begin
        k = idx_of(BrPC);
        m_bht[k] = tk ? ((m_bht[k] + 1 > 3) ? 3 : m_bht[k] + 1)
                      : ((m_bht[k] - 1 < 0) ? 0 : m_bht[k] - 1);
        if (m_bc < CNT_MAX) m_bc++;
      end
      if (mp && m_mc < CNT_MAX) m_mc++;
      m_mis = mp;
      m_err = BrValid && !lg;
    end
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("BrUn", BrUn, Funct3[1]);
      chk("Taken", Taken, ref_taken(BrValid, Funct3, BrEq, BrLT));
      chk("PredTaken", PredTaken, m_bht[idx_of(LookupPC)] >= 2);
      chk("Mispredict", Mispredict, m_mis);
      chk("BrErr", BrErr, m_err);
      chk("BranchCount", BranchCount, m_bc);
      chk("MispredictCount", MispredictCount, m_mc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit [2:0] f3, input logic [31:0] pc,
                       input bit pt, input bit eq, input bit lt, input logic [31:0] lk);
    BrValid = v; Funct3 = f3; BrPC = pc; BrPredTaken = pt;
    BrEq = eq; BrLT = lt; LookupPC = lk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit v; bit [2:0] f3; logic [31:0] pc; bit pt; bit eq; bit lt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 3'd1, 32'h120, 1, 1, 0};  // BNE not taken, mispredict
    tbl[1]  = '{1, 3'd1, 32'h120, 0, 0, 0};  // BNE taken, mispredict
    tbl[2]  = '{1, 3'd4, 32'h124, 1, 0, 1};  // BLT taken
    tbl[3]  = '{1, 3'd4, 32'h124, 1, 1, 0};  // BLT not taken
    tbl[4]  = '{1, 3'd5, 32'h128, 0, 0, 0};  // BGE taken
    tbl[5]  = '{1, 3'd5, 32'h128, 1, 0, 1};  // BGE not taken
    tbl[6]  = '{1, 3'd7, 32'h124, 1, 0, 0};  // BGEU taken
    tbl[7]  = '{1, 3'd7, 32'h124, 0, 0, 1};  // BGEU not taken
    tbl[8]  = '{0, 3'd0, 32'h120, 1, 1, 0};  // idle
    tbl[9]  = '{1, 3'd3, 32'h128, 1, 1, 1};  // illegal 011
    tbl[10] = '{1, 3'd6, 32'h120, 0, 0, 1};  // BLTU taken
    tbl[11] = '{1, 3'd0, 32'h128, 0, 0, 0};  // BEQ not taken

    // 1: reset
    reset = 1;
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h100);
    tick(); tick();
    chk("t1_pred", PredTaken, 1'b0);
    chk("t1_bcnt", BranchCount, 0);
    chk("t1_mcnt", MispredictCount, 0);
    chk("t1_mis", Mispredict, 1'b0);
    reset = 0;

    // 2: BEQ taken, predicted not taken
    drive(1, 3'd0, 32'h100, 0, 1, 0, 32'h100);
    chk("t2_taken", Taken, 1'b1);
    chk("t2_pred_before", PredTaken, 1'b0);
    tick();
    drive(0, 3'd0, 32'h100, 0, 0, 0, 32'h100);
    chk("t2_mis", Mispredict, 1'b1);
    chk("t2_bcnt", BranchCount, 1);
    chk("t2_mcnt", MispredictCount, 1);
    chk("t2_pred_after", PredTaken, 1'b1);
    tick();
    chk("t2_mis_pulse", Mispredict, 1'b0);

    // 3: BrUn and BLTU saturation at 00
    drive(0, 3'd6, 32'h0, 0, 0, 0, 32'h104);
    chk("t3_brun_110", BrUn, 1'b1);
    drive(0, 3'd4, 32'h0, 0, 0, 0, 32'h104);
    chk("t3_brun_100", BrUn, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd6, 32'h104, 0, 0, 0, 32'h104);
      chk("t3_bltu_taken", Taken, 1'b0);
      tick();
    end
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h104);
    chk("t3_pred", PredTaken, 1'b0);
    drive(1, 3'd6, 32'h104, 0, 0, 1, 32'h104);
    tick();
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h104);
    chk("t3_pred_from_00", PredTaken, 1'b0);

    // 4: illegal funct3
    drive(1, 3'd2, 32'h100, 1, 1, 1, 32'h100);
    chk("t4_taken", Taken, 1'b0);
    tick();
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h100);
    chk("t4_err", BrErr, 1'b1);
    chk("t4_mis", Mispredict, 1'b0);
    tick();
    chk("t4_err_clear", BrErr, 1'b0);

    // directed table, checked by the model
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].f3, tbl[i].pc, tbl[i].pt, tbl[i].eq, tbl[i].lt, tbl[i].pc);
      tick();
    end

    // 5: same-index read/update (index 3)
    drive(1, 3'd0, 32'h0C, 1, 1, 0, 32'h0C);
    chk("t5_old", PredTaken, 1'b0);
    tick();
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h0C);
    chk("t5_new", PredTaken, 1'b1);

    // 6: saturate both counters, then reset alongside a branch
    for (int i = 0; i < 20; i++) begin
      drive(1, 3'd0, 32'h100, 0, 1, 0, 32'h100);
      tick();
    end
    drive(1, 3'd0, 32'h100, 1, 1, 0, 32'h100);
    tick();
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h100);
    chk("t6_bcnt_sat", BranchCount, CNT_MAX);
    chk("t6_mcnt_sat", MispredictCount, CNT_MAX);
    chk("t6_pred", PredTaken, 1'b1);
    reset = 1;
    drive(1, 3'd2, 32'h100, 0, 1, 0, 32'h100);
    tick();
    drive(1, 3'd0, 32'h100, 0, 1, 0, 32'h100);
    chk("t6_taken_in_reset", Taken, 1'b1);
    tick();
    reset = 0;
    drive(0, 3'd0, 32'h0, 0, 0, 0, 32'h100);
    chk("t6_bcnt_rst", BranchCount, 0);
    chk("t6_mcnt_rst", MispredictCount, 0);
    chk("t6_mis_rst", Mispredict, 1'b0);
    chk("t6_err_rst", BrErr, 1'b0);
    chk("t6_pred_rst", PredTaken, 1'b0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
